cu_seq: RTL and testbench

- Parametrised instruction-phase sequencer; successor to the fixed-topology control unit.
- Drives chip-select / ready handshakes to the fetch unit, decoder, NUM_EU execution units and the bus interface unit, in order per instruction.
- Owns the PC. Adds branch redirect, a per-phase watchdog and sticky fault reporting.
- Sits at the core top, between the fetch/decode/execute/bus blocks.

---
 rtl/cu_seq_pkg.sv | 20 ++
 rtl/cu_seq_wdog.sv | 29 ++
 rtl/cu_seq.sv | 205 ++++++++++++++++++++
 tb/tb_cu_seq.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/cu_seq_pkg.sv
// Shared types and constants for the cu_seq instruction-phase sequencer.
package cu_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_BUS    = 3'd4,
        ST_FAULT  = 3'd5
    } state_t;

    localparam logic [1:0] FLT_NONE  = 2'b00;
    localparam logic [1:0] FLT_TMO   = 2'b01;
    localparam logic [1:0] FLT_BADEU = 2'b11;

    // Sequential PC step; the sum is truncated to ADDR_W so the PC wraps silently.
    localparam int unsigned PC_STEP = 1;

endpackage

// File: rtl/cu_seq_wdog.sv
// Per-phase watchdog: counts stalled handshake cycles, flags expiry at 2**TMO_W-1.
module cu_seq_wdog #(
    parameter int unsigned TMO_W = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic expire_c
);

    localparam logic [TMO_W-1:0] CNT_LAST = TMO_W'((2 ** TMO_W) - 2);

    logic [TMO_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + TMO_W'(1);
        end
    end

    // This stalled cycle is the one that brings the count to its limit.
    assign expire_c = en && (cnt == CNT_LAST);

endmodule

// File: rtl/cu_seq.sv
// Instruction-phase sequencer: fetch/decode/execute/bus handshakes, PC, watchdog, faults.
// Optional: CU_PERF_CNT_EN enables the 32-bit retired-instruction counter.
module cu_seq
    import cu_seq_pkg::*;
#(
    parameter int unsigned IR_W     = 32,
    parameter int unsigned ADDR_W   = 16,
    parameter int unsigned NUM_EU   = 2,
    parameter int unsigned EU_IDX_W = 3,
    parameter int unsigned TMO_W    = 8,
    parameter int unsigned RESET_PC = 0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                run,
    output logic                cs_fcu,
    input  logic                ready_fcu,
    output logic [ADDR_W-1:0]   fetch_address,
    input  logic [IR_W-1:0]     ir_in,
    output logic                cs_dec,
    input  logic                ready_dec,
    input  logic [EU_IDX_W-1:0] dec_eu_idx,
    input  logic                dec_mem,
    output logic [NUM_EU-1:0]   cs_eu,
    input  logic [NUM_EU-1:0]   ready_eu,
    input  logic                br_taken,
    input  logic [ADDR_W-1:0]   br_target,
    output logic                cs_biu,
    input  logic                ready_biu,
    output logic [IR_W-1:0]     ir,
    output logic                busy,
    output logic                fault,
    output logic [1:0]          fault_code,
    output logic [31:0]         instr_count
);

    state_t              state, state_nxt;
    logic                cs_fcu_nxt, cs_dec_nxt, cs_biu_nxt;
    logic [NUM_EU-1:0]   cs_eu_nxt;
    logic [IR_W-1:0]     ir_nxt;
    logic [ADDR_W-1:0]   pc, pc_nxt;
    logic                mem_q, mem_nxt;
    logic                br_taken_q, br_taken_nxt;
    logic [ADDR_W-1:0]   br_target_q, br_target_nxt;
    logic                busy_nxt, fault_nxt;
    logic [1:0]          fault_code_nxt;
    logic                retire_c, ret_taken_c, eu_done_c, bad_idx_c;
    logic [ADDR_W-1:0]   ret_target_c;
    logic                wd_en_c, wd_clr_c, wd_expire_c;

    assign fetch_address = pc;
    assign eu_done_c     = |(ready_eu & cs_eu);
    assign bad_idx_c     = 32'(dec_eu_idx) >= 32'(NUM_EU);

    // Branch info comes live on an EXEC retire, from the latched copy on a BUS retire.
    assign ret_taken_c  = (state == ST_BUS) ? br_taken_q  : br_taken;
    assign ret_target_c = (state == ST_BUS) ? br_target_q : br_target;

    assign wd_en_c  = (cs_fcu & ~ready_fcu) | (cs_dec & ~ready_dec)
                    | ((|cs_eu) & ~eu_done_c) | (cs_biu & ~ready_biu);
    assign wd_clr_c = (state_nxt != state);

    cu_seq_wdog #(.TMO_W(TMO_W)) u_wdog (
        .clk      (clk),
        .reset    (reset),
        .clr      (wd_clr_c),
        .en       (wd_en_c),
        .expire_c (wd_expire_c)
    );

    // Next-state and next-output logic.
    always_comb begin
        state_nxt      = state;
        cs_fcu_nxt     = cs_fcu;
        cs_dec_nxt     = cs_dec;
        cs_eu_nxt      = cs_eu;
        cs_biu_nxt     = cs_biu;
        ir_nxt         = ir;
        pc_nxt         = pc;
        mem_nxt        = mem_q;
        br_taken_nxt   = br_taken_q;
        br_target_nxt  = br_target_q;
        fault_nxt      = fault;
        fault_code_nxt = fault_code;
        retire_c       = 1'b0;

        case (state)
            ST_IDLE: begin
                if (run) begin
                    state_nxt  = ST_FETCH;
                    cs_fcu_nxt = 1'b1;
                end
            end
            ST_FETCH: begin
                if (cs_fcu && ready_fcu) begin
                    ir_nxt     = ir_in;
                    cs_fcu_nxt = 1'b0;
                    cs_dec_nxt = 1'b1;
                    state_nxt  = ST_DECODE;
                end
            end
            ST_DECODE: begin
                if (cs_dec && ready_dec) begin
                    cs_dec_nxt = 1'b0;
                    if (bad_idx_c) begin
                        state_nxt      = ST_FAULT;
                        fault_nxt      = 1'b1;
                        fault_code_nxt = FLT_BADEU;
                    end else begin
                        state_nxt = ST_EXEC;
                        cs_eu_nxt = NUM_EU'(1) << dec_eu_idx;
                        mem_nxt   = dec_mem;
                    end
                end
            end
            ST_EXEC: begin
                if (eu_done_c) begin
                    cs_eu_nxt     = '0;
                    br_taken_nxt  = br_taken;
                    br_target_nxt = br_target;
                    if (mem_q) begin
                        state_nxt  = ST_BUS;
                        cs_biu_nxt = 1'b1;
                    end else begin
                        retire_c = 1'b1;
                    end
                end
            end
            ST_BUS: begin
                if (cs_biu && ready_biu) begin
                    cs_biu_nxt = 1'b0;
                    retire_c   = 1'b1;
                end
            end
            default: ;
        endcase

        if (retire_c) begin
            pc_nxt     = ret_taken_c ? ret_target_c : pc + ADDR_W'(PC_STEP);
            state_nxt  = run ? ST_FETCH : ST_IDLE;
            cs_fcu_nxt = run;
        end

        if (wd_expire_c) begin
            state_nxt      = ST_FAULT;
            cs_fcu_nxt     = 1'b0;
            cs_dec_nxt     = 1'b0;
            cs_eu_nxt      = '0;
            cs_biu_nxt     = 1'b0;
            fault_nxt      = 1'b1;
            fault_code_nxt = FLT_TMO;
        end

        busy_nxt = (state_nxt != ST_IDLE) && (state_nxt != ST_FAULT);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            cs_fcu      <= 1'b0;
            cs_dec      <= 1'b0;
            cs_eu       <= '0;
            cs_biu      <= 1'b0;
            ir          <= '0;
            pc          <= ADDR_W'(RESET_PC);
            mem_q       <= 1'b0;
            br_taken_q  <= 1'b0;
            br_target_q <= '0;
            busy        <= 1'b0;
            fault       <= 1'b0;
            fault_code  <= FLT_NONE;
        end else begin
            state       <= state_nxt;
            cs_fcu      <= cs_fcu_nxt;
            cs_dec      <= cs_dec_nxt;
            cs_eu       <= cs_eu_nxt;
            cs_biu      <= cs_biu_nxt;
            ir          <= ir_nxt;
            pc          <= pc_nxt;
            mem_q       <= mem_nxt;
            br_taken_q  <= br_taken_nxt;
            br_target_q <= br_target_nxt;
            busy        <= busy_nxt;
            fault       <= fault_nxt;
            fault_code  <= fault_code_nxt;
        end
    end

`ifdef CU_PERF_CNT_EN
    logic [31:0] retired;

    always_ff @(posedge clk) begin
        if (reset) begin
            retired <= '0;
        end else if (retire_c) begin
            retired <= retired + 32'd1;
        end
    end

    assign instr_count = retired;
`else
    assign instr_count = '0;
`endif

endmodule

// File: tb/tb_cu_seq.sv
// Directed self-checking bench for cu_seq (NUM_EU=2, TMO_W=4).
module tb_cu_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic        run;
    logic        cs_fcu;
    logic        ready_fcu;
    logic [15:0] fetch_address;
    logic [31:0] ir_in;
    logic        cs_dec;
    logic        ready_dec;
    logic [2:0]  dec_eu_idx;
    logic        dec_mem;
    logic [1:0]  cs_eu;
    logic [1:0]  ready_eu;
    logic        br_taken;
    logic [15:0] br_target;
    logic        cs_biu;
    logic        ready_biu;
    logic [31:0] ir;
    logic        busy;
    logic        fault;
    logic [1:0]  fault_code;
    logic [31:0] instr_count;

    int checks = 0;
    int errors = 0;
    int hi_cnt;

    cu_seq #(
        .IR_W(32), .ADDR_W(16), .NUM_EU(2), .EU_IDX_W(3), .TMO_W(4), .RESET_PC(0)
    ) dut (
        .clk(clk), .reset(reset), .run(run),
        .cs_fcu(cs_fcu), .ready_fcu(ready_fcu), .fetch_address(fetch_address), .ir_in(ir_in),
        .cs_dec(cs_dec), .ready_dec(ready_dec), .dec_eu_idx(dec_eu_idx), .dec_mem(dec_mem),
        .cs_eu(cs_eu), .ready_eu(ready_eu), .br_taken(br_taken), .br_target(br_target),
        .cs_biu(cs_biu), .ready_biu(ready_biu), .ir(ir), .busy(busy),
        .fault(fault), .fault_code(fault_code), .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] exp_cnt(input int n);
`ifdef CU_PERF_CNT_EN
        return 32'(n);
`else
        return 32'(n - n);
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fetch_op(input logic [31:0] word);
        ir_in = word; ready_fcu = 1'b1;
        tick();
        ready_fcu = 1'b0;
    endtask

    task automatic dec_op(input logic [2:0] idx, input logic mem);
        dec_eu_idx = idx; dec_mem = mem; ready_dec = 1'b1;
        tick();
        ready_dec = 1'b0;
    endtask

    task automatic eu_op(input logic [1:0] rdy, input logic taken, input logic [15:0] tgt);
        ready_eu = rdy; br_taken = taken; br_target = tgt;
        tick();
        ready_eu = '0; br_taken = 1'b0; br_target = '0;
    endtask

    initial begin
        reset = 1'b1; run = 1'b0; ready_fcu = 1'b0; ir_in = '0; ready_dec = 1'b0;
        dec_eu_idx = '0; dec_mem = 1'b0; ready_eu = '0; br_taken = 1'b0;
        br_target = '0; ready_biu = 1'b0;
        tick(); tick();
        reset = 1'b0;
        check("rst_cs", {cs_fcu, cs_dec, cs_eu, cs_biu}, 64'h0);
        check("rst_busy_fault", {busy, fault, fault_code}, 64'h0);
        check("rst_pc", fetch_address, 64'h0);
        check("rst_ir", ir, 64'h0);
        check("rst_cnt", instr_count, 64'h0);

        // Basic no-bus instruction on EU 1
        run = 1'b1;
        tick();
        check("t1_fetch_cs", {cs_fcu, busy}, 64'h3);
        fetch_op(32'hDEAD_BEEF);
        check("t1_dec_cs", {cs_fcu, cs_dec}, 64'h1);
        check("t1_ir", ir, 64'hDEAD_BEEF);
        dec_op(3'd1, 1'b0);
        check("t1_eu_cs", {cs_dec, cs_eu}, 64'h2);
        eu_op(2'b10, 1'b0, 16'h0);
        check("t1_retire_cs", {cs_eu, cs_fcu}, 64'h1);
        check("t1_pc", fetch_address, 64'h1);
        check("t1_cnt", instr_count, 64'(exp_cnt(1)));

        // Bus phase held for five cycles
        fetch_op(32'h1111_2222);
        dec_op(3'd0, 1'b1);
        check("t2_eu_cs", cs_eu, 64'h1);
        eu_op(2'b01, 1'b0, 16'h0);
        check("t2_bus_cs", {cs_eu, cs_biu}, 64'h1);
        check("t2_pc_hold", fetch_address, 64'h1);
        hi_cnt = cs_biu ? 1 : 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (cs_biu) hi_cnt++;
        end
        ready_biu = 1'b1;
        tick();
        ready_biu = 1'b0;
        check("t2_biu_cycles", 64'(hi_cnt), 64'd5);
        check("t2_biu_drop", {cs_biu, cs_fcu}, 64'h1);
        check("t2_pc", fetch_address, 64'h2);
        check("t2_cnt", instr_count, 64'(exp_cnt(2)));

        // Taken branch
        fetch_op(32'h3);
        dec_op(3'd1, 1'b0);
        eu_op(2'b10, 1'b1, 16'h0040);
        check("t3_branch_pc", fetch_address, 64'h0040);
        check("t3_cnt", instr_count, 64'(exp_cnt(3)));

        // Branch to FFFF, then sequential wrap with a spurious ready on the wrong EU
        fetch_op(32'h4);
        dec_op(3'd1, 1'b0);
        eu_op(2'b10, 1'b1, 16'hFFFF);
        check("t4_pc_ffff", fetch_address, 64'hFFFF);
        fetch_op(32'h5);
        dec_op(3'd1, 1'b0);
        ready_eu = 2'b01;
        tick();
        ready_eu = '0;
        check("t4_spurious_eu", {cs_eu, busy}, 64'h5);
        check("t4_spurious_pc", fetch_address, 64'hFFFF);
        run = 1'b0;
        eu_op(2'b10, 1'b0, 16'h0);
        check("t4_wrap_pc", fetch_address, 64'h0);
        check("t4_run_low", {cs_fcu, busy, cs_eu}, 64'h0);
        check("t4_cnt", instr_count, 64'(exp_cnt(5)));
        tick();
        check("t4_stay_idle", {cs_fcu, busy}, 64'h0);

        // Decode never answers: watchdog fires after 15 stalled cycles
        run = 1'b1;
        tick();
        fetch_op(32'h6);
        for (int i = 0; i < 14; i++) tick();
        check("t5_before_tmo", {cs_dec, fault}, 64'h2);
        tick();
        check("t5_tmo", {fault, fault_code}, 64'h5);
        check("t5_tmo_cs", {cs_dec, busy, cs_fcu}, 64'h0);
        ready_dec = 1'b1;
        tick(); tick();
        ready_dec = 1'b0;
        check("t5_sticky", {fault, fault_code, cs_dec, cs_eu, busy}, 64'h50);
        check("t5_pc_hold", fetch_address, 64'h0);

        // Bad EU index
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("t6_rst_clear", {fault, fault_code}, 64'h0);
        tick();
        fetch_op(32'h7);
        dec_op(3'd3, 1'b0);
        check("t6_badeu", {fault, fault_code}, 64'h7);
        check("t6_no_eu", {cs_eu, busy}, 64'h0);
        tick();
        check("t6_no_eu_later", cs_eu, 64'h0);

        // Reset in the middle of a fetch handshake
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        check("t7_fetch_up", cs_fcu, 64'h1);
        ir_in = 32'hCAFE_F00D; ready_fcu = 1'b1; reset = 1'b1; run = 1'b0;
        tick();
        reset = 1'b0;
        check("t7_rst_cs", {cs_fcu, cs_dec, cs_eu, cs_biu}, 64'h0);
        check("t7_rst_misc", {busy, fault, fault_code}, 64'h0);
        check("t7_rst_ir", ir, 64'h0);
        check("t7_rst_cnt", instr_count, 64'h0);
        tick();
        ready_fcu = 1'b0;
        check("t7_ready_ignored", {ir, cs_dec, busy}, 64'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
